module_keypad_scan: RTL and testbench

MODULE_KEYPAD_SCAN -- requirements
Module: module_keypad_scan

---
 rtl/pkg_keypad.sv | 34 +++
 rtl/module_scan_timer.sv | 27 ++
 rtl/module_keypad_scan.sv | 144 ++++++++++++++
 tb/tb_module_keypad_scan.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pkg_keypad.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map, column drive.
package pkg_keypad;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StPressed,
    StReleaseWait
  } state_e;

  // Nibble at index {row, col}: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = E 0 F D.
  localparam logic [63:0] KeyMap = 64'hDF0E_C987_B654_A321;

  // Active-low column drive per column index: 1110, 1101, 1011, 0111.
  localparam logic [15:0] ColDrive = 16'h7BDE;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return KeyMap[{row, col, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ColDrive[{col, 2'b00} +: 4];
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/module_scan_timer.sv
// Column-slot timer: counts one slot of 10 MHz cycles and flags the last cycle of each slot.
module module_scan_timer #(
  parameter int unsigned FREC_SCAN = 1_000,
  parameter int unsigned BITS_SCAN = 14
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int unsigned SlotLen = 10_000_000 / FREC_SCAN;
  localparam logic [BITS_SCAN-1:0] SlotLast = BITS_SCAN'(SlotLen - 1);

  logic [BITS_SCAN-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == SlotLast);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + BITS_SCAN'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/module_keypad_scan.sv
// 4x4 keypad scanner: rotates an active-low column, debounces press and release of one key,
// and shifts each accepted key code into an eight-digit hex history.
module module_keypad_scan
  import pkg_keypad::*;
#(
  parameter int unsigned FREC_SCAN      = 1_000,
  parameter int unsigned BITS_SCAN      = 14,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic        clk_10Mhz_i,
  input  logic        reset_i,
  input  logic [3:0]  row_i,
  output logic [3:0]  col_o,
  output logic [3:0]  key_code_o,
  output logic        key_valid_o,
  output logic        key_held_o,
  output logic [31:0] digits_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_TICKS - 1);

  logic            tick;
  logic [3:0]      row_meta_q, row_sync_q;
  state_e          state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;
  logic            row_low;
  logic [3:0]      code_q;
  logic            valid_q;
  logic [31:0]     digits_q;

  module_scan_timer #(
    .FREC_SCAN(FREC_SCAN),
    .BITS_SCAN(BITS_SCAN)
  ) u_timer (
    .clk_i  (clk_10Mhz_i),
    .reset_i(reset_i),
    .tick_o (tick)
  );

  // Rows are asynchronous to the clock; idle level is high.
  always_ff @(posedge clk_10Mhz_i) begin
    if (reset_i) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row_i;
      row_sync_q <= row_meta_q;
    end
  end

  always_ff @(posedge clk_10Mhz_i) begin
    if (reset_i) begin
      state_q <= StScan;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outside scanning only the latched row is observed.
  assign row_low = ~row_sync_q[row_q];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (&row_sync_q) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d   = first_low(row_sync_q);
            cnt_d   = '0;
            state_d = StDebounce;
          end
        end
        StDebounce: begin
          if (row_low) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
              state_d = StPressed;
              accept  = 1'b1;
            end
          end else begin
            state_d = StScan;
            col_d   = col_q + 2'd1;
          end
        end
        StPressed: begin
          if (!row_low) begin
            state_d = StReleaseWait;
            cnt_d   = '0;
          end
        end
        StReleaseWait: begin
          if (row_low) begin
            state_d = StPressed;
          end else if (cnt_q == CntLast) begin
            state_d = StScan;
            col_d   = col_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk_10Mhz_i) begin
    if (reset_i) begin
      code_q   <= '0;
      valid_q  <= 1'b0;
      digits_q <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        code_q   <= key_code(row_q, col_q);
        digits_q <= {digits_q[27:0], key_code(row_q, col_q)};
      end
    end
  end

  always_comb begin
    col_o       = col_drive(col_q);
    key_code_o  = code_q;
    key_valid_o = valid_q;
    key_held_o  = (state_q == StPressed) || (state_q == StReleaseWait);
    digits_o    = digits_q;
  end

endmodule

// File: tb/tb_module_keypad_scan.sv
// Bench for module_keypad_scan: directed key presses with a queue of expected accepts,
// drained by a monitor on every key_valid_o pulse.
`timescale 1ns/1ps
module tb_module_keypad_scan;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] digits;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic [3:0]  key_code_o;
  logic        key_valid_o;
  logic        key_held_o;
  logic [31:0] digits_o;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_valid = 0;
  logic        key_down = 1'b0;
  logic [1:0]  key_r = 2'd0;
  logic [1:0]  key_c = 2'd0;
  logic [31:0] exp_digits = 32'h0;

  always #50 clk = ~clk;

  module_keypad_scan #(
    .FREC_SCAN     (1_000_000),
    .BITS_SCAN     (4),
    .DEBOUNCE_TICKS(4)
  ) dut (
    .clk_10Mhz_i(clk),
    .reset_i    (reset_i),
    .row_i      (row_i),
    .col_o      (col_o),
    .key_code_o (key_code_o),
    .key_valid_o(key_valid_o),
    .key_held_o (key_held_o),
    .digits_o   (digits_o)
  );

  // Keypad model: the pressed key pulls its row low only while its column is driven.
  always_comb begin
    row_i = 4'hF;
    if (key_down && !col_o[key_c]) row_i[key_r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (key_valid_o === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got code %h digits %h, required no pulse",
                 key_code_o, digits_o);
      end else begin
        e = exp_q.pop_front();
        check("valid_code", {28'h0, key_code_o}, {28'h0, e.code});
        check("valid_digits", digits_o, e.digits);
      end
    end
  end

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    exp_digits = 32'h0;
  endtask

  task automatic wait_held(input logic v, input int budget);
    for (int i = 0; i < budget && key_held_o !== v; i++) @(negedge clk);
  endtask

  task automatic press_hold(input logic [1:0] r, input logic [1:0] c, input logic [3:0] code);
    exp_digits = {exp_digits[27:0], code};
    exp_q.push_back('{code, exp_digits});
    key_r = r;
    key_c = c;
    key_down = 1'b1;
    wait_held(1'b1, 200);
    check("held_rise", {31'h0, key_held_o}, 32'h1);
  endtask

  task automatic release_key();
    repeat (50) @(negedge clk);
    check("held_steady", {31'h0, key_held_o}, 32'h1);
    key_down = 1'b0;
    repeat (5) @(negedge clk);
    check("held_release_window", {31'h0, key_held_o}, 32'h1);
    wait_held(1'b0, 200);
    check("held_fall", {31'h0, key_held_o}, 32'h0);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, {28'h0, col_o}, 32'hE);
    check({tag, "_code"}, {28'h0, key_code_o}, 32'h0);
    check({tag, "_valid"}, {31'h0, key_valid_o}, 32'h0);
    check({tag, "_held"}, {31'h0, key_held_o}, 32'h0);
    check({tag, "_digits"}, digits_o, 32'h0);
  endtask

  initial begin
    logic [3:0] col_exp[5];
    int v0;
    col_exp = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

    do_reset();
    check_reset_outputs("reset");

    // Idle scan: column advances every 10-cycle slot.
    v0 = n_valid;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("idle_col%0d", i), {28'h0, col_o}, {28'h0, col_exp[i]});
      repeat (10) @(negedge clk);
    end
    check("idle_no_valid", n_valid - v0, 0);

    // Key 6 held steady, then released.
    press_hold(2'd1, 2'd2, 4'h6);
    repeat (5) @(negedge clk);
    check("key6_code", {28'h0, key_code_o}, 32'h6);
    check("key6_digits", digits_o, 32'h0000_0006);
    release_key();

    // Bounce on key 5: low for the detect tick and one debounce tick only.
    v0 = n_valid;
    for (int i = 0; i < 100 && col_o === 4'b1101; i++) @(negedge clk);
    for (int i = 0; i < 100 && col_o !== 4'b1101; i++) @(negedge clk);
    key_r = 2'd1;
    key_c = 2'd1;
    key_down = 1'b1;
    repeat (25) @(negedge clk);
    key_down = 1'b0;
    repeat (7) @(negedge clk);
    check("bounce_col_adv", {28'h0, col_o}, 32'hB);
    check("bounce_held", {31'h0, key_held_o}, 32'h0);
    repeat (60) @(negedge clk);
    check("bounce_no_valid", n_valid - v0, 0);

    // Keys 1..9 from a clean history; the first digit shifts out.
    do_reset();
    v0 = n_valid;
    for (int i = 0; i < 9; i++) begin
      press_hold(2'(i / 3), 2'(i % 3), 4'(i + 1));
      release_key();
    end
    check("seq_digits", digits_o, 32'h2345_6789);
    check("seq_pulses", n_valid - v0, 9);

    // Reset while key A is held.
    press_hold(2'd0, 2'd3, 4'hA);
    repeat (10) @(negedge clk);
    reset_i = 1'b1;
    key_down = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    exp_digits = 32'h0;
    check_reset_outputs("midpress");
    v0 = n_valid;
    repeat (100) @(negedge clk);
    check("midpress_no_valid", n_valid - v0, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
